// File: rtl/rv32i_lsu.sv
// ============================================================================
// Module      : rv32i_lsu
// Description : RV32I load/store unit. Runs one data-memory transaction at a
//               time over a req/gnt/rvalid bus, forms store lanes and extends
//               load data. Optional macro LSU_MISALIGN_TRAP_EN turns misaligned
//               accesses into error responses instead of silently aligning.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32i_lsu #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_load,
  input  logic        req_is_store,
  input  logic [2:0]  req_ld_op,
  input  logic [1:0]  req_st_frmt,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [4:0]  rsp_rd,
  output logic        rsp_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [15:0] C_TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  logic [15:0] cnt_q;
  logic [2:0]  ld_op_q;
  logic [1:0]  off_q;
  logic [4:0]  rd_q;
  logic        is_load_q;

  logic        w_kind_ok;
  logic        w_ld_ok;
  logic        w_st_ok;
  logic        w_is_half;
  logic        w_is_word;
  logic        w_misalign;
  logic        w_legal;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_shifted;
  logic [15:0] w_half;
  logic [31:0] w_ld_data;

  assign req_ready = (state_q == S_IDLE) && !rst;

  // Request legality and misalignment decode
  always_comb begin
    w_kind_ok  = req_is_load ^ req_is_store;
    w_ld_ok    = !((req_ld_op == 3'b011) || (req_ld_op[2:1] == 2'b11));
    w_st_ok    = (req_st_frmt != 2'b11);
    w_is_half  = req_is_load ? (req_ld_op[1:0] == 2'b01) : (req_st_frmt == 2'b01);
    w_is_word  = req_is_load ? (req_ld_op[1:0] == 2'b10) : (req_st_frmt == 2'b10);
    w_misalign = (w_is_half && req_addr[0]) || (w_is_word && (req_addr[1:0] != 2'b00));
`ifdef LSU_MISALIGN_TRAP_EN
    w_legal    = w_kind_ok && (req_is_load ? w_ld_ok : w_st_ok) && !w_misalign;
`else
    w_legal    = w_kind_ok && (req_is_load ? w_ld_ok : w_st_ok);
`endif
  end

  // Store lane formation; loads read the full word
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = 32'h0;
    if (req_is_store) begin
      case (req_st_frmt)
        2'b00: begin
          w_be    = 4'b0001 << req_addr[1:0];
          w_wdata = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{req_wdata[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = req_wdata;
        end
      endcase
    end
  end

  // Load lane extraction from the live bus data, captured on rvalid
  always_comb begin
    w_shifted = dmem_rdata >> {off_q, 3'b000};
    w_half    = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (ld_op_q)
      3'b000:  w_ld_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
      3'b100:  w_ld_data = {24'h0, w_shifted[7:0]};
      3'b101:  w_ld_data = {16'h0, w_half};
      default: w_ld_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 16'd0;
      ld_op_q    <= 3'd0;
      off_q      <= 2'd0;
      rd_q       <= 5'd0;
      is_load_q  <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'h0;
      dmem_be    <= 4'h0;
      dmem_wdata <= 32'h0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 32'h0;
      rsp_rd     <= 5'd0;
      rsp_err    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            cnt_q     <= 16'd0;
            ld_op_q   <= req_ld_op;
            off_q     <= req_addr[1:0];
            rd_q      <= req_rd;
            is_load_q <= req_is_load;
            if (w_legal) begin
              state_q    <= S_ADDR;
              dmem_req   <= 1'b1;
              dmem_we    <= req_is_store;
              dmem_addr  <= {req_addr[31:2], 2'b00};
              dmem_be    <= w_be;
              dmem_wdata <= w_wdata;
            end else begin
              state_q   <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0;
              rsp_rd    <= req_rd;
            end
          end
        end

        S_ADDR, S_WAIT: begin
          cnt_q <= cnt_q + 16'd1;
          // A real response in the final cycle wins over the timeout
          if ((dmem_rvalid && (state_q == S_WAIT)) || (dmem_gnt && dmem_rvalid)) begin
            state_q   <= S_RESP;
            dmem_req  <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= is_load_q ? w_ld_data : 32'h0;
            rsp_rd    <= rd_q;
          end else if (cnt_q == C_TO_LAST) begin
            state_q   <= S_RESP;
            dmem_req  <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= 32'h0;
            rsp_rd    <= rd_q;
          end else if (dmem_gnt && (state_q == S_ADDR)) begin
            state_q  <= S_WAIT;
            dmem_req <= 1'b0;
          end
        end

        default: begin
          state_q   <= S_IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rv32i_lsu.sv
// Directed scoreboard bench for rv32i_lsu with a short timeout for error paths.
`default_nettype none

module tb_rv32i_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_load;
  logic        req_is_store;
  logic [2:0]  req_ld_op;
  logic [1:0]  req_st_frmt;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [4:0]  rsp_rd;
  logic        rsp_err;

  typedef struct packed {
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        err;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  rv32i_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_is_load (req_is_load),
    .req_is_store(req_is_store),
    .req_ld_op   (req_ld_op),
    .req_st_frmt (req_st_frmt),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_rd      (req_rd),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_be     (dmem_be),
    .dmem_wdata  (dmem_wdata),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_rd      (rsp_rd),
    .rsp_err     (rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
    if (sbq.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s.sb observed=empty expected=entry", tag);
    end else begin
      e = sbq.pop_front();
      chk({tag, ".rdata"}, rsp_rdata, e.rdata);
      chk({tag, ".rd"}, 32'(rsp_rd), 32'(e.rd));
      chk({tag, ".err"}, 32'(rsp_err), 32'(e.err));
    end
  endtask

  task automatic drive(input logic ld, input logic st, input logic [2:0] ldop,
                       input logic [1:0] frmt, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] rd);
    req_valid    = 1'b1;
    req_is_load  = ld;
    req_is_store = st;
    req_ld_op    = ldop;
    req_st_frmt  = frmt;
    req_addr     = addr;
    req_wdata    = wd;
    req_rd       = rd;
  endtask

  task automatic idle_req();
    req_valid    = 1'b0;
    req_is_load  = 1'b0;
    req_is_store = 1'b0;
  endtask

  // Legal op: grant together with rvalid after gdelay extra ADDR cycles
  task automatic do_op(input string tag, input logic ld, input logic st,
                       input logic [2:0] ldop, input logic [1:0] frmt,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                       input logic [31:0] e_addr, input logic [3:0] e_be, input logic [31:0] e_wd,
                       input int gdelay, input logic [31:0] mem_rd, input logic [31:0] e_rdata);
    chk({tag, ".ready"}, 32'(req_ready), 32'd1);
    drive(ld, st, ldop, frmt, addr, wd, rd);
    sbq.push_back('{rdata: e_rdata, rd: rd, err: 1'b0});
    tick();
    idle_req();
    chk({tag, ".dmem_req"}, 32'(dmem_req), 32'd1);
    chk({tag, ".dmem_we"}, 32'(dmem_we), 32'(st));
    chk({tag, ".dmem_addr"}, dmem_addr, e_addr);
    chk({tag, ".dmem_be"}, 32'(dmem_be), 32'(e_be));
    if (st) chk({tag, ".dmem_wdata"}, dmem_wdata, e_wd);
    for (int k = 0; k < gdelay; k++) begin
      tick();
      chk({tag, ".req_held"}, 32'(dmem_req), 32'd1);
      chk({tag, ".addr_held"}, dmem_addr, e_addr);
    end
    dmem_gnt    = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = mem_rd;
    tick();
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
    pop_check(tag);
    chk({tag, ".req_drop"}, 32'(dmem_req), 32'd0);
    tick();
    chk({tag, ".one_pulse"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".ready_back"}, 32'(req_ready), 32'd1);
  endtask

  task automatic illegal_op(input string tag, input logic ld, input logic st,
                            input logic [2:0] ldop, input logic [1:0] frmt,
                            input logic [31:0] addr, input logic [4:0] rd);
    chk({tag, ".ready"}, 32'(req_ready), 32'd1);
    drive(ld, st, ldop, frmt, addr, 32'hFFFF_FFFF, rd);
    sbq.push_back('{rdata: 32'h0, rd: rd, err: 1'b1});
    tick();
    idle_req();
    pop_check(tag);
    chk({tag, ".no_req"}, 32'(dmem_req), 32'd0);
    tick();
    chk({tag, ".no_req2"}, 32'(dmem_req), 32'd0);
    chk({tag, ".one_pulse"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".ready_back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst         = 1'b1;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
    req_ld_op   = 3'd0;
    req_st_frmt = 2'd0;
    req_addr    = 32'h0;
    req_wdata   = 32'h0;
    req_rd      = 5'd0;
    idle_req();
    tick();
    tick();

    // Reset state
    chk("rst.ready", 32'(req_ready), 32'd0);
    chk("rst.dmem_req", 32'(dmem_req), 32'd0);
    chk("rst.dmem_we", 32'(dmem_we), 32'd0);
    chk("rst.dmem_addr", dmem_addr, 32'h0);
    chk("rst.dmem_be", 32'(dmem_be), 32'h0);
    chk("rst.dmem_wdata", dmem_wdata, 32'h0);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.rsp_rdata", rsp_rdata, 32'h0);
    chk("rst.rsp_rd", 32'(rsp_rd), 32'd0);
    chk("rst.rsp_err", 32'(rsp_err), 32'd0);
    rst = 1'b0;
    #1;

    // Stores
    do_op("sb", 1'b0, 1'b1, 3'd0, 2'b00, 32'h0000_1003, 32'h1234_56A5, 5'd3,
          32'h0000_1000, 4'b1000, 32'hA5A5_A5A5, 0, 32'h0, 32'h0);
    do_op("sh", 1'b0, 1'b1, 3'd0, 2'b01, 32'h0000_0012, 32'h5555_BEEF, 5'd7,
          32'h0000_0010, 4'b1100, 32'hBEEF_BEEF, 1, 32'h0, 32'h0);
    do_op("sw", 1'b0, 1'b1, 3'd0, 2'b10, 32'h0000_0020, 32'hCAFE_F00D, 5'd8,
          32'h0000_0020, 4'b1111, 32'hCAFE_F00D, 0, 32'h0, 32'h0);

    // Loads
    do_op("lb", 1'b1, 1'b0, 3'b000, 2'b00, 32'h0000_2002, 32'h0, 5'd17,
          32'h0000_2000, 4'b1111, 32'h0, 2, 32'h0080_0000, 32'hFFFF_FF80);
    do_op("lbu", 1'b1, 1'b0, 3'b100, 2'b00, 32'h0000_2002, 32'h0, 5'd17,
          32'h0000_2000, 4'b1111, 32'h0, 2, 32'h0080_0000, 32'h0000_0080);
    do_op("lhu", 1'b1, 1'b0, 3'b101, 2'b00, 32'h0000_2002, 32'h0, 5'd12,
          32'h0000_2000, 4'b1111, 32'h0, 1, 32'h8001_0000, 32'h0000_8001);
    do_op("lw", 1'b1, 1'b0, 3'b010, 2'b00, 32'h0000_4000, 32'h0, 5'd31,
          32'h0000_4000, 4'b1111, 32'h0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // Load through the WAIT state: grant first, rvalid two cycles later
    chk("wait.ready", 32'(req_ready), 32'd1);
    drive(1'b1, 1'b0, 3'b000, 2'b00, 32'h0000_7001, 32'h0, 5'd21);
    sbq.push_back('{rdata: 32'h0000_007F, rd: 5'd21, err: 1'b0});
    tick();
    idle_req();
    chk("wait.dmem_req", 32'(dmem_req), 32'd1);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    chk("wait.req_low", 32'(dmem_req), 32'd0);
    chk("wait.no_rsp", 32'(rsp_valid), 32'd0);
    tick();
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h0000_7F00;
    tick();
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
    pop_check("wait");
    tick();

    // Misaligned half
`ifdef LSU_MISALIGN_TRAP_EN
    illegal_op("lh_mis", 1'b1, 1'b0, 3'b001, 2'b00, 32'h0000_3001, 5'd6);
`else
    do_op("lh_mis", 1'b1, 1'b0, 3'b001, 2'b00, 32'h0000_3001, 32'h0, 5'd6,
          32'h0000_3000, 4'b1111, 32'h0, 1, 32'h1234_8765, 32'hFFFF_8765);
`endif

    // Illegal encodings
    illegal_op("ld110", 1'b1, 1'b0, 3'b110, 2'b00, 32'h0000_0100, 5'd9);
    illegal_op("both", 1'b1, 1'b1, 3'b010, 2'b10, 32'h0000_0104, 5'd10);
    illegal_op("neither", 1'b0, 1'b0, 3'b010, 2'b10, 32'h0000_0108, 5'd11);
    illegal_op("st11", 1'b0, 1'b1, 3'b000, 2'b11, 32'h0000_010C, 5'd13);

    // Timeout with grant held low
    chk("to.ready", 32'(req_ready), 32'd1);
    drive(1'b1, 1'b0, 3'b010, 2'b00, 32'h0000_5000, 32'h0, 5'd9);
    sbq.push_back('{rdata: 32'h0, rd: 5'd9, err: 1'b1});
    tick();
    idle_req();
    for (int k = 0; k < 4; k++) begin
      chk("to.req_high", 32'(dmem_req), 32'd1);
      chk("to.no_rsp", 32'(rsp_valid), 32'd0);
      tick();
    end
    pop_check("to");
    chk("to.req_drop", 32'(dmem_req), 32'd0);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hFFFF_FFFF;
    tick();
    chk("late.no_rsp", 32'(rsp_valid), 32'd0);
    chk("late.ready", 32'(req_ready), 32'd1);
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
    do_op("after_to", 1'b1, 1'b0, 3'b001, 2'b00, 32'h0000_5002, 32'h0, 5'd14,
          32'h0000_5000, 4'b1111, 32'h0, 0, 32'h7ABC_0000, 32'h0000_7ABC);

    // Reset while in WAIT
    chk("rw.ready", 32'(req_ready), 32'd1);
    drive(1'b1, 1'b0, 3'b010, 2'b00, 32'h0000_6000, 32'h0, 5'd4);
    tick();
    idle_req();
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    chk("rw.in_wait", 32'(dmem_req), 32'd0);
    rst = 1'b1;
    tick();
    chk("rw.ready_rst", 32'(req_ready), 32'd0);
    chk("rw.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rw.dmem_req", 32'(dmem_req), 32'd0);
    chk("rw.dmem_we", 32'(dmem_we), 32'd0);
    chk("rw.dmem_addr", dmem_addr, 32'h0);
    chk("rw.dmem_be", 32'(dmem_be), 32'h0);
    chk("rw.rsp_rdata", rsp_rdata, 32'h0);
    chk("rw.rsp_rd", 32'(rsp_rd), 32'd0);
    rst = 1'b0;
    #1;
    chk("rw.ready_back", 32'(req_ready), 32'd1);
    tick();
    chk("rw.still_quiet", 32'(rsp_valid), 32'd0);
    chk("sb.empty", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
